// File: rtl/mc_main_fsm.sv
// ---------------------------------------------------------------------------
// mc_main_fsm
// Main control state machine for the multicycle RV32I datapath. Sequences
// fetch / decode / execute / memory / writeback for lw, sw, R-type, I-type
// ALU, beq and jal; every other opcode parks the machine in TRAP until reset.
// All outputs are decoded from the current state. The exceptions are
// ir_write, pc_write and retire, which also follow mem_ready and zero within
// the same cycle.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   opcode[6:0]   instr[6:0] from the instruction register
//   zero          ALU zero flag
//   mem_ready     memory access completes this cycle
//   alu_op[1:0]   to the ALU decoder: 00 add, 01 sub, 10 funct-decoded
//   alu_src_a     00 PC, 01 oldPC, 10 rd1
//   alu_src_b     00 rd2, 01 imm, 10 constant 4
//   result_src    00 ALUOut, 01 read data, 10 ALU result
//   adr_src       0 PC, 1 result
//   ir_write      instruction register load enable
//   pc_write      PC load enable
//   reg_write     register file write enable
//   mem_write     data memory write enable
//   retire        one-cycle pulse on the final cycle of each instruction
//   illegal_instr sticky trap flag
//   state_dbg     current state encoding
// ---------------------------------------------------------------------------
module mc_main_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       retire,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  localparam int unsigned STATE_W = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t state;
  state_t state_nxt;

  logic rdy;
  logic pc_update;
  logic branch;
  logic ir_write_d;
  logic reg_write_d;
  logic mem_write_d;
  logic retire_d;
  logic illegal_d;

  // With waiting disabled every memory access is treated as single-cycle.
  assign rdy = mem_ready | ~MEM_WAIT_EN;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_nxt   = S_FETCH;
    alu_op      = ALU_ADD;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    result_src  = RES_ALUOUT;
    adr_src     = 1'b0;
    ir_write_d  = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    reg_write_d = 1'b0;
    mem_write_d = 1'b0;
    retire_d    = 1'b0;
    illegal_d   = 1'b0;

    case (state)
      S_FETCH: begin
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALURES;
        ir_write_d = rdy;
        pc_update  = rdy;
        state_nxt  = rdy ? S_DECODE : S_FETCH;
      end

      // ALUOut <= oldPC + imm so a following BEQ has its target ready.
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        state_nxt  = rdy ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        result_src  = RES_RDATA;
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
        state_nxt   = S_FETCH;
      end

      // The write strobe is held until memory accepts it.
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        result_src  = RES_ALUOUT;
        mem_write_d = 1'b1;
        retire_d    = rdy;
        state_nxt   = rdy ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALU_FUNCT;
        state_nxt = S_ALUWB;
      end

      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_nxt = S_ALUWB;
      end

      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
        state_nxt   = S_FETCH;
      end

      // PC takes the precomputed target from ALUOut only when rs1 == rs2.
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        retire_d   = 1'b1;
        state_nxt  = S_FETCH;
      end

      // PC <= target from ALUOut while oldPC + 4 is formed for ALUWB.
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_nxt  = S_ALUWB;
      end

      S_TRAP: begin
        illegal_d = 1'b1;
        state_nxt = S_TRAP;
      end

      // Unused encodings fall back to FETCH.
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Enables are forced low for the whole reset window, not only after the
  // state register has cleared.
  assign ir_write      = ir_write_d & rst_n;
  assign pc_write      = (pc_update | (branch & zero)) & rst_n;
  assign reg_write     = reg_write_d & rst_n;
  assign mem_write     = mem_write_d & rst_n;
  assign retire        = retire_d & rst_n;
  assign illegal_instr = illegal_d & rst_n;
  assign state_dbg     = STATE_W'(state);

endmodule

// File: tb/tb_mc_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_main_fsm
// Self-checking bench for mc_main_fsm: a directed vector table, hand-written
// reset and trap sequences, and a randomized instruction stream checked
// against a per-instruction state-path model.
// ---------------------------------------------------------------------------
module tb_mc_main_fsm;

  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_BEQ = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6f;
  localparam logic [6:0] OP_ILL = 7'h73;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       retire;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  mc_main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .retire       (retire),
    .illegal_instr(illegal_instr),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Selects per state: {alu_op, alu_src_a, alu_src_b, result_src, adr_src}.
  function automatic logic [8:0] exp_sel(input int st);
    case (st)
      0:  exp_sel = {2'd0, 2'd0, 2'd2, 2'd2, 1'b0};
      1:  exp_sel = {2'd0, 2'd1, 2'd1, 2'd0, 1'b0};
      2:  exp_sel = {2'd0, 2'd2, 2'd1, 2'd0, 1'b0};
      3:  exp_sel = {2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
      4:  exp_sel = {2'd0, 2'd0, 2'd0, 2'd1, 1'b0};
      5:  exp_sel = {2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
      6:  exp_sel = {2'd2, 2'd2, 2'd0, 2'd0, 1'b0};
      7:  exp_sel = {2'd2, 2'd2, 2'd1, 2'd0, 1'b0};
      8:  exp_sel = {2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
      9:  exp_sel = {2'd1, 2'd2, 2'd0, 2'd0, 1'b0};
      10: exp_sel = {2'd0, 2'd1, 2'd2, 2'd0, 1'b0};
      default: exp_sel = 9'd0;
    endcase
  endfunction

  // Enables: {ir_write, pc_write, reg_write, mem_write, retire, illegal_instr}.
  function automatic logic [5:0] exp_en(input int st, input bit r, input bit z);
    bit irw, pcw, rw, mw, ret, ill;
    irw = (st == 0) && r;
    pcw = irw || (st == 10) || ((st == 9) && z);
    rw  = (st == 4) || (st == 8);
    mw  = (st == 5);
    ret = rw || (st == 9) || ((st == 5) && r);
    ill = (st == 11);
    exp_en = {irw, pcw, rw, mw, ret, ill};
  endfunction

  task automatic check_all(input string tag, input int st, input bit r, input bit z);
    chk({tag, "_state"}, 32'(state_dbg), 32'(st));
    chk({tag, "_sel"}, 32'({alu_op, alu_src_a, alu_src_b, result_src, adr_src}),
        32'(exp_sel(st)));
    chk({tag, "_en"}, 32'({ir_write, pc_write, reg_write, mem_write, retire, illegal_instr}),
        32'(exp_en(st, r, z)));
    chk({tag, "_rw_mw_excl"}, 32'(reg_write & mem_write), 32'd0);
  endtask

  // Directed vectors: one row per cycle.
  typedef struct {
    logic [6:0] opc;
    logic       rdy;
    logic       z;
    logic [3:0] st;
    logic [1:0] aop;
    logic [4:0] en;   // {ir_write, pc_write, reg_write, mem_write, retire}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [6:0] o, input logic r, input logic z,
                     input int st, input int aop, input logic [4:0] en);
    vec_t v;
    v.opc = o; v.rdy = r; v.z = z; v.st = 4'(st); v.aop = 2'(aop); v.en = en;
    vecs.push_back(v);
  endtask

  // Random-phase model: remaining state path of the current instruction.
  int         path[$];
  logic [6:0] cur_op;

  task automatic pick_instr();
    case ($urandom_range(0, 5))
      0:       begin cur_op = OP_LW;  path = '{0, 1, 2, 3, 4}; end
      1:       begin cur_op = OP_SW;  path = '{0, 1, 2, 5};    end
      2:       begin cur_op = OP_R;   path = '{0, 1, 6, 8};    end
      3:       begin cur_op = OP_I;   path = '{0, 1, 7, 8};    end
      4:       begin cur_op = OP_BEQ; path = '{0, 1, 9};       end
      default: begin cur_op = OP_JAL; path = '{0, 1, 10, 8};   end
    endcase
  endtask

  initial begin
    int  st;
    bit  r, z;
    int  done_cnt, ret_cnt;

    // lw with one FETCH wait and one MEMREAD wait.
    add(OP_LW, 0, 0, 0, 0, 5'b00000);
    add(OP_LW, 1, 0, 0, 0, 5'b11000);
    add(OP_LW, 1, 1, 1, 0, 5'b00000);
    add(OP_LW, 1, 0, 2, 0, 5'b00000);
    add(OP_LW, 0, 0, 3, 0, 5'b00000);
    add(OP_LW, 1, 0, 3, 0, 5'b00000);
    add(OP_LW, 1, 0, 4, 0, 5'b00101);
    // R-type and I-type; mem_ready low must not stall EXECUTEI.
    add(OP_R, 1, 0, 0, 0, 5'b11000);
    add(OP_R, 1, 0, 1, 0, 5'b00000);
    add(OP_R, 1, 1, 6, 2, 5'b00000);
    add(OP_R, 1, 0, 8, 0, 5'b00101);
    add(OP_I, 1, 0, 0, 0, 5'b11000);
    add(OP_I, 1, 0, 1, 0, 5'b00000);
    add(OP_I, 0, 0, 7, 2, 5'b00000);
    add(OP_I, 1, 0, 8, 0, 5'b00101);
    // beq taken, then not taken.
    add(OP_BEQ, 1, 0, 0, 0, 5'b11000);
    add(OP_BEQ, 1, 0, 1, 0, 5'b00000);
    add(OP_BEQ, 1, 1, 9, 1, 5'b01001);
    add(OP_BEQ, 1, 0, 0, 0, 5'b11000);
    add(OP_BEQ, 1, 1, 1, 0, 5'b00000);
    add(OP_BEQ, 1, 0, 9, 1, 5'b00001);
    // sw with three wait cycles in MEMWRITE: 7 cycles total.
    add(OP_SW, 1, 1, 0, 0, 5'b11000);
    add(OP_SW, 1, 0, 1, 0, 5'b00000);
    add(OP_SW, 1, 0, 2, 0, 5'b00000);
    add(OP_SW, 0, 1, 5, 0, 5'b00010);
    add(OP_SW, 0, 0, 5, 0, 5'b00010);
    add(OP_SW, 0, 1, 5, 0, 5'b00010);
    add(OP_SW, 1, 0, 5, 0, 5'b00011);
    // jal.
    add(OP_JAL, 1, 0, 0, 0, 5'b11000);
    add(OP_JAL, 1, 0, 1, 0, 5'b00000);
    add(OP_JAL, 1, 0, 10, 0, 5'b01000);
    add(OP_JAL, 1, 0, 8, 0, 5'b00101);

    // Reset: mem_ready high must not leak through to ir_write/pc_write.
    rst_n = 1'b0; opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_en", 32'({ir_write, pc_write, reg_write, mem_write, retire, illegal_instr}), 32'd0);
    chk("reset_sel", 32'({alu_op, alu_src_a, alu_src_b, result_src, adr_src}), 32'(exp_sel(0)));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      opcode = vecs[i].opc; mem_ready = vecs[i].rdy; zero = vecs[i].z;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
      chk($sformatf("vec%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].aop));
      chk($sformatf("vec%0d_en", i), 32'({ir_write, pc_write, reg_write, mem_write, retire}),
          32'(vecs[i].en));
    end

    // Asynchronous reset in the middle of a stalled MEMWRITE.
    @(negedge clk); opcode = OP_SW; mem_ready = 1'b1; zero = 1'b0; #1;
    chk("rst_mid_fetch", 32'(state_dbg), 32'd0);
    @(negedge clk); #1;
    chk("rst_mid_decode", 32'(state_dbg), 32'd1);
    @(negedge clk); #1;
    chk("rst_mid_memadr", 32'(state_dbg), 32'd2);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("rst_mid_memwrite", 32'(state_dbg), 32'd5);
    chk("rst_mid_mw_hi", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_async_mw", 32'(mem_write), 32'd0);
    chk("rst_async_state", 32'(state_dbg), 32'd0);
    chk("rst_async_en", 32'({ir_write, pc_write, retire}), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_state", 32'(state_dbg), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_rel_irw_pcw", 32'({ir_write, pc_write}), 32'b11);
    @(posedge clk); #1;
    chk("rst_rel_decode", 32'(state_dbg), 32'd1);

    // Illegal opcode from DECODE: TRAP holds with all enables low.
    @(negedge clk); opcode = OP_ILL; #1;
    chk("trap_decode", 32'(state_dbg), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      opcode = (c == 10) ? OP_LW : OP_ILL;
      #1;
      check_all($sformatf("trap%0d", c), 11, mem_ready, zero);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    chk("trap_rst_state", 32'(state_dbg), 32'd0);
    chk("trap_rst_illegal", 32'(illegal_instr), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // Random instruction stream against the path model.
    done_cnt = 0;
    ret_cnt  = 0;
    pick_instr();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = ($urandom_range(0, 3) != 0);
      z = 1'($urandom_range(0, 1));
      opcode = cur_op; mem_ready = r; zero = z;
      #1;
      st = path[0];
      check_all("rnd", st, r, z);
      if (retire) ret_cnt++;
      if (!(((st == 0) || (st == 3) || (st == 5)) && !r)) begin
        path.delete(0);
        if (path.size() == 0) begin
          done_cnt++;
          pick_instr();
        end
      end
    end
    chk("rnd_retire_count", 32'(ret_cnt), 32'(done_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
- Main control state machine for the multicycle RV32I datapath variant.
- Sits directly upstream of the ALU decoder: it sequences fetch, decode, execute, memory and writeback, and drives `alu_op` into the ALU decoder alongside funct3/funct7b5 taken from the instruction register.
- It also produces all datapath mux selects and write enables.
- It supports lw, sw, R-type, I-type ALU, beq and jal. Any other opcode traps.

Parameters:
- MEM_WAIT_EN, 1, when 1 the memory states wait for `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instr[6:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete in the current cycle
- alu_op  output  2  to the ALU decoder: 00 add, 01 sub, 10 funct-decoded
- alu_src_a  output  2  00 PC, 01 oldPC, 10 rd1
- alu_src_b  output  2  00 rd2, 01 imm, 10 constant 4
- result_src  output  2  00 ALUOut, 01 read data, 10 ALU result
- adr_src  output  1  0 PC, 1 result
- ir_write  output  1  instruction register load enable
- pc_write  output  1  PC load enable
- reg_write  output  1  register file write enable
- mem_write  output  1  data memory write enable
- retire  output  1  one-cycle pulse on the final cycle of each instruction
- illegal_instr  output  1  sticky trap flag
- state_dbg  output  4  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11. Codes 12-15 are unreachable and recover to FETCH on the next edge.
- Reset (`rst_n` low, asynchronous, usable at any time including mid-instruction): state=FETCH. While in reset, all enables (`ir_write`, `pc_write`, `reg_write`, `mem_write`, `retire`) are 0, `illegal_instr`=0 and `state_dbg`=0. Selects reflect FETCH values.
- `rdy` = `mem_ready` | ~MEM_WAIT_EN.
- Outputs are decoded from the current state only. Exceptions: `pc_write`, `ir_write` and `retire` also depend on the inputs named below.
- Any output not listed for a state is 0.
- Internal signals: `pc_update`, `branch`. `pc_write` = `pc_update` | (`branch` & `zero`).
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=rdy, pc_update=rdy.
  - Next state: DECODE if rdy, else FETCH.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target computed into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other -> TRAP.
- MEMADR:
  - alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next state: MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD:
  - adr_src=1, result_src=00.
  - Next state: MEMWB if rdy, else hold.
- MEMWB:
  - result_src=01, reg_write=1, retire=1.
  - Next state: FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00, mem_write=1.
  - mem_write stays asserted every cycle until rdy.
  - retire=rdy.
  - Next state: FETCH if rdy, else hold.
- EXECUTER:
  - alu_src_a=10, alu_src_b=00, alu_op=10.
  - Next state: ALUWB.
- EXECUTEI:
  - alu_src_a=10, alu_src_b=01, alu_op=10.
  - Next state: ALUWB.
- ALUWB:
  - result_src=00, reg_write=1, retire=1.
  - Next state: FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, retire=1.
  - Next state: FETCH. PC is loaded only if zero=1.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
  - Next state: ALUWB, which writes PC+4 to rd.
- TRAP:
  - All enables 0, illegal_instr=1.
  - Stays in TRAP until reset.
- Cycle counts with mem_ready always high:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and I-type ALU: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
  - Each cycle of mem_ready low adds one cycle, in FETCH, MEMREAD or MEMWRITE only.
- Invariants:
  - reg_write and mem_write are never high in the same cycle.
  - retire pulses exactly once per completed instruction.

Test Plan:
- Reset during MEMWRITE with mem_ready=0: assert rst_n=0 -> mem_write drops to 0 immediately (no clock edge needed), state_dbg=0; after release, first edge with mem_ready=1 -> ir_write=1, pc_write=1.
- lw (opcode 0000011), mem_ready=1 -> state_dbg sequence 0,1,2,3,4,0; reg_write=1 only in state 4; retire single pulse.
- R-type add (0110011) then I-type (0010011) -> alu_op=10 in states 6 and 7 respectively; ALUWB reg_write=1; 4 cycles each.
- beq with zero=1, then again with zero=0 -> pc_write=1 in BEQ only for zero=1; alu_op=01 in both; 3 cycles each.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write held high for 4 cycles; retire asserted only in the cycle mem_ready=1; total 7 cycles.
- Illegal opcode 1110011 -> TRAP after DECODE, illegal_instr=1, all enables 0 for 20 cycles; recovers to FETCH only after rst_n pulse.
